// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: MSB-first magnitude compare of two words through one external 1-bit comparator.
// Define EARLY_EXIT_EN to stop at the first differing bit (variable latency); default is constant time.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             lesser,
  output logic             equals,
  output logic             greater
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic found_q, found_d, rgt_q, rgt_d;
  logic first, last, decisive, accept, lt_now;
  always_comb begin
    first = !cmp_eq && !found_q;
    last = idx_q == '0;
`ifdef EARLY_EXIT_EN
    decisive = first || last;
`else
    decisive = last;
`endif
    // eq > gt > lt priority; an all-zero response falls through to lesser
    lt_now = !cmp_gt && (cmp_lt || !cmp_eq);
    accept = start && (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    lt_d = lt_q;
    eq_d = eq_q;
    gt_d = gt_q;
    found_d = found_q;
    rgt_d = rgt_q;
    if (state_q == COMPARE) begin
      found_d = found_q || first;
      rgt_d = first ? cmp_gt : rgt_q;
      state_d = decisive ? DONE : COMPARE;
      idx_d = decisive ? idx_q : idx_q - 1'b1;
      gt_d = decisive ? (first ? cmp_gt : found_q && rgt_q) : gt_q;
      lt_d = decisive ? (first ? lt_now : found_q && !rgt_q) : lt_q;
      eq_d = decisive ? !first && !found_q : eq_q;
    end else if (accept) begin
      state_d = COMPARE;
      a_d = a_in;
      b_d = b_in;
      idx_d = IW'(WIDTH - 1);
      {lt_d, eq_d, gt_d, found_d, rgt_d} = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      {lt_q, eq_q, gt_q, found_q, rgt_q} <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      {lt_q, eq_q, gt_q, found_q, rgt_q} <= {lt_d, eq_d, gt_d, found_d, rgt_d};
    end
  end
  assign busy = state_q == COMPARE;
  assign done = state_q == DONE;
  assign cmp_a = busy && a_q[idx_q];
  assign cmp_b = busy && b_q[idx_q];
  assign lesser = lt_q;
  assign equals = eq_q;
  assign greater = gt_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl: scoreboard bench with a behavioural one-bit comparator on the cmp_* pins.
`ifdef EARLY_EXIT_EN
`define LAT(e) (e)
`else
`define LAT(e) (9)
`endif
module tb_serial_compare_ctrl;
  localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001;
  typedef struct {logic [2:0] flags; int lat; int s;} exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] a_in = 0, b_in = 0;
  logic cmp_a, cmp_b, cmp_lt, cmp_eq, cmp_gt, busy, done, lesser, equals, greater;
  int cyc = 0, checks = 0, fails = 0;
  exp_t q[$];
  serial_compare_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .lesser(lesser), .equals(equals), .greater(greater)
  );
  assign cmp_lt = !cmp_a && cmp_b;
  assign cmp_eq = cmp_a == cmp_b;
  assign cmp_gt = cmp_a && !cmp_b;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("flags", {lesser, equals, greater}, e.flags);
        chk("latency", cyc - e.s + 1, e.lat);
        chk("busy_in_done", busy, 0);
      end
    end
  end
  task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f, input int lat);
    a_in = a;
    b_in = b;
    start = 1;
    q.push_back('{f, lat, cyc + 1});
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) chk("done_timeout", 0, 1);
  endtask
  initial begin
    logic [7:0] v;
    #1;
    chk("rst_outs", {busy, done, lesser, equals, greater, cmp_a, cmp_b}, 0);
    @(posedge clk);
    #1 rst = 0;
    do_start(8'h80, 8'h7F, GT, `LAT(2));
    wait_done();
    @(posedge clk);
    #1 v = 8'h3C;
    do_start(v, v, EQ, 9);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      chk("busy_seq", busy, 1);
      chk("cmp_a_seq", cmp_a, v[i]);
      chk("cmp_b_seq", cmp_b, v[i]);
    end
    wait_done();
    @(posedge clk);
    #1 do_start(8'h01, 8'h02, LT, `LAT(8));
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_flags", {lesser, equals, greater}, LT);
      chk("hold_idle", {busy, done, cmp_a, cmp_b}, 0);
    end
    @(posedge clk);
    #1 do_start(8'h10, 8'h20, LT, `LAT(4));
    a_in = 8'hFF;
    b_in = 8'h00;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("ignored_start_busy", busy, 1);
    wait_done();
    @(posedge clk);
    #1 do_start(8'h05, 8'h04, GT, 9);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort_outs", {busy, done, lesser, equals, greater, cmp_a, cmp_b}, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {busy, done}, 0);
    @(posedge clk);
    #1 do_start(8'h40, 8'h60, LT, `LAT(4));
    wait_done();
    do_start(8'hAA, 8'h55, GT, `LAT(2));
    chk("restart_busy", busy, 1);
    chk("restart_cleared", {lesser, equals, greater}, 0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
